// File: rtl/nbit_pipe_sub.sv
// nbit_pipe_sub
//   Pipelined subtractor D = A - B - Bi, one 4-bit slice per stage.
//   Each stage adds A + ~B + carry over one nibble using a 4-bit lookahead.
//   The carry chain carries ~borrow. Latency is Q = DATA_WIDTH/4 cycles.
//   Flow control is a global stall: every stage advances together when the
//   output slot is empty or is being consumed.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle
//   A, B, Bi   minuend, subtrahend, borrow in
//   out_valid  result beat present
//   out_ready  consumer accepts the result
//   D          difference modulo 2^DATA_WIDTH
//   Bo         borrow out (unsigned underflow)
//   V          signed overflow
//   Z          D == 0
module nbit_pipe_sub #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Bi,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] D,
    output logic                  Bo,
    output logic                  V,
    output logic                  Z
);

    localparam int Q  = DATA_WIDTH / 4;
    // Stages 1..Q-1 live in these arrays; stage Q is the output register set.
    // Padded to one entry so the declarations stay legal when Q == 1.
    localparam int NI = (Q > 1) ? Q - 1 : 1;

    generate
        if ((DATA_WIDTH < 4) || ((DATA_WIDTH % 4) != 0)) begin : g_bad_width
            $error("nbit_pipe_sub: DATA_WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    // One nibble of a + ~b + cin with full 4-bit carry lookahead.
    // Returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] nib_sub(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic       cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & ~b;
        p    = a ^ ~b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Internal stage registers
    logic                  sv_q [NI];
    logic                  sc_q [NI];
    logic [DATA_WIDTH-1:0] sa_q [NI];
    logic [DATA_WIDTH-1:0] sb_q [NI];
    logic [DATA_WIDTH-1:0] sd_q [NI];

    // Per-stage inputs and the nibble each stage produces
    logic                  src_v [Q];
    logic                  src_c [Q];
    logic [DATA_WIDTH-1:0] src_a [Q];
    logic [DATA_WIDTH-1:0] src_b [Q];
    logic [DATA_WIDTH-1:0] src_d [Q];
    logic [4:0]            res   [Q];
    logic [DATA_WIDTH-1:0] new_d [Q];

    logic adv;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & reset_n;

    always_comb begin
        for (int unsigned k = 0; k < Q; k++) begin
            if (k == 0) begin
                src_v[k] = in_valid;
                src_c[k] = ~Bi;
                src_a[k] = A;
                src_b[k] = B;
                src_d[k] = '0;
            end else begin
                src_v[k] = sv_q[k-1];
                src_c[k] = sc_q[k-1];
                src_a[k] = sa_q[k-1];
                src_b[k] = sb_q[k-1];
                src_d[k] = sd_q[k-1];
            end
            res[k]            = nib_sub(src_a[k][4*k +: 4], src_b[k][4*k +: 4], src_c[k]);
            new_d[k]          = src_d[k];
            new_d[k][4*k +: 4] = res[k][3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NI; k++) begin
                sv_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int unsigned k = 0; k + 1 < Q; k++) begin
                sv_q[k] <= src_v[k];
                sc_q[k] <= res[k][4];
                sa_q[k] <= src_a[k];
                sb_q[k] <= src_b[k];
                sd_q[k] <= new_d[k];
            end
        end
    end

    // Output results only load on a valid beat so the reset values remain
    // visible until the first real result arrives.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            D         <= '0;
            Bo        <= 1'b0;
            V         <= 1'b0;
            Z         <= 1'b0;
        end else if (adv) begin
            out_valid <= src_v[Q-1];
            if (src_v[Q-1]) begin
                D  <= new_d[Q-1];
                Bo <= ~res[Q-1][4];
                V  <= (src_a[Q-1][DATA_WIDTH-1] ^ src_b[Q-1][DATA_WIDTH-1])
                    & (src_a[Q-1][DATA_WIDTH-1] ^ new_d[Q-1][DATA_WIDTH-1]);
                Z  <= (new_d[Q-1] == '0);
            end
        end
    end

endmodule
